c28soi_pm_control_lr_async_tdc_dr_driver: RTL

//  On-chip initiator for the TDC control/sense user data register (UDR) chain.
//  - Takes one parallel request from a host: a write word plus capture/update flags.
//  - Generates the capture/shift/update strobes and the serial data that the UDR consumes.
//  - Collects the UDR serial_out stream and returns the shifted-out word to the host.
//  - Sits between a register-bus host bridge and one UDR instance on the same clock.

---
 rtl/c28soi_pm_control_lr_async_tdc_dr_driver.sv | 104 ++++++++++
 1 files changed

// File: rtl/c28soi_pm_control_lr_async_tdc_dr_driver.sv
// Host-side initiator for the TDC control/sense UDR chain: turns one parallel
// request into capture/shift/update strobes and returns the shifted-out word.
module c28soi_pm_control_lr_async_tdc_dr_driver #(
   parameter int DR_LENGTH = 16,
   parameter int CNT_W     = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [DR_LENGTH-1:0] req_wdata,
   input  logic                 req_capture,
   input  logic                 req_update,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [DR_LENGTH-1:0] rsp_rdata,
   output logic                 busy,
   output logic                 dr_capture,
   output logic                 dr_shift,
   output logic                 dr_update,
   output logic                 dr_serial_in,
   input  logic                 dr_serial_out
);

   typedef enum logic [2:0] {
      IDLE,
      CAPTURE,
      SHIFT,
      UPDATE,
      RESP
   } state_t;

   state_t               state;
   state_t               state_next;
   logic [CNT_W-1:0]     cnt;
   logic [DR_LENGTH-1:0] tx_sr;
   logic [DR_LENGTH-1:0] rx_sr;
   logic                 do_update;
   logic                 accept;
   logic                 last_shift;

   assign accept     = req_valid & req_ready;
   assign last_shift = (cnt == CNT_W'(DR_LENGTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = req_capture ? CAPTURE : SHIFT;
            end
         end
         CAPTURE: state_next = SHIFT;
         SHIFT: begin
            if (last_shift) begin
               state_next = do_update ? UPDATE : RESP;
            end
         end
         UPDATE: state_next = RESP;
         RESP: begin
            if (rsp_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The capture flag only steers the IDLE exit, so only the update flag is kept.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         tx_sr     <= '0;
         rx_sr     <= '0;
         do_update <= 1'b0;
      end else if (accept) begin
         cnt       <= '0;
         tx_sr     <= req_wdata;
         do_update <= req_update;
      end else if (state == SHIFT) begin
         cnt   <= cnt + CNT_W'(1);
         tx_sr <= tx_sr >> 1;
         rx_sr <= {dr_serial_out, rx_sr[DR_LENGTH-1:1]};
      end
   end

   assign req_ready    = (state == IDLE) & ~rst;
   assign busy         = (state != IDLE);
   assign dr_capture   = (state == CAPTURE);
   assign dr_shift     = (state == SHIFT);
   assign dr_update    = (state == UPDATE);
   assign dr_serial_in = (state == SHIFT) & tx_sr[0];
   assign rsp_valid    = (state == RESP);
   assign rsp_rdata    = rx_sr;

endmodule
